nsc_cmd_slave: RTL and testbench



---
 rtl/nsc_cmd_pkg.sv | 40 ++++
 rtl/nsc_cmd_regfile.sv | 85 ++++++++
 rtl/nsc_cmd_slave.sv | 272 +++++++++++++++++++++++++++
 tb/tb_nsc_cmd_slave.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nsc_cmd_pkg.sv
// nsc_cmd_pkg: shared constants, response codes, FSM state types and helpers
// for the NSC helper-command AXI4 responder.
package nsc_cmd_pkg;

   localparam logic [31:0] ID_VALUE    = 32'h4E53_0001;
   localparam logic [15:0] ADDR_MASK   = 16'hFFFF;

   localparam logic [15:0] OFF_ID      = 16'h0000;
   localparam logic [15:0] OFF_CC      = 16'h3000;
   localparam logic [15:0] OFF_STATUS  = 16'h3004;
   localparam logic [15:0] OFF_SP_BASE = 16'h4000;
   localparam int          SP_COUNT    = 7;

   localparam int CC_BUSY    = 0;
   localparam int CC_DONE    = 1;
   localparam int CC_OVERRUN = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_RESP, W_DRAIN} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}          r_state_t;

   // Word address (byte address bits [15:2]) hits one of SP0..SP6.
   function automatic logic sp_hit(input logic [13:0] waddr);
      return (waddr[13:3] == OFF_SP_BASE[15:5]) && (waddr[2:0] != 3'd7);
   endfunction

   // Byte-lane merge of new data into an existing word.
   function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++)
         if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
      return res;
   endfunction

endpackage

// File: rtl/nsc_cmd_regfile.sv
// nsc_cmd_regfile: address decode, byte-strobed SP/CC/STATUS storage and the
// combinational read mux. Addresses arrive as masked word addresses.
module nsc_cmd_regfile import nsc_cmd_pkg::*; (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [13:0]               wr_addr,
   input  logic [31:0]               wr_data,
   input  logic [3:0]                wr_strb,
   output logic                      wr_ok,
   input  logic [13:0]               rd_addr,
   output logic [31:0]               rd_data,
   output logic                      rd_ok,
   input  logic                      launch,
   input  logic                      complete,
   input  logic                      overrun,
   input  logic [31:0]               status_in,
   output logic                      busy,
   output logic [SP_COUNT-1:0][31:0] sp
);

   logic        done_q, ovr_q;
   logic [31:0] status_q;
   logic        wr_cc, wr_sp;

   assign wr_cc = (wr_addr == OFF_CC[15:2]);
   assign wr_sp = sp_hit(wr_addr);
   assign wr_ok = wr_cc || wr_sp;

   // Scratchpad storage, byte-strobed, writable at any time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
      end else if (wr_en && wr_sp) begin
         for (int i = 0; i < SP_COUNT; i++)
            if (wr_addr[2:0] == 3'(i)) sp[i] <= strb_merge(sp[i], wr_data, wr_strb);
      end
   end

   // CC/STATUS: W1C clears first, then completion, then a new launch wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         status_q <= '0;
      end else begin
         if (wr_en && wr_cc && wr_strb[0]) begin
            if (wr_data[CC_DONE])    done_q <= 1'b0;
            if (wr_data[CC_OVERRUN]) ovr_q  <= 1'b0;
         end
         if (complete) begin
            busy     <= 1'b0;
            done_q   <= 1'b1;
            status_q <= status_in;
         end
         if (overrun) ovr_q <= 1'b1;
         if (launch) begin
            busy   <= 1'b1;
            done_q <= 1'b0;
         end
      end
   end

   // Read mux; unmapped addresses read as zero with rd_ok low.
   always_comb begin
      rd_data = '0;
      rd_ok   = 1'b0;
      if (rd_addr == OFF_ID[15:2]) begin
         rd_ok   = 1'b1;
         rd_data = ID_VALUE;
      end else if (rd_addr == OFF_CC[15:2]) begin
         rd_ok   = 1'b1;
         rd_data = {29'b0, ovr_q, done_q, busy};
      end else if (rd_addr == OFF_STATUS[15:2]) begin
         rd_ok   = 1'b1;
         rd_data = status_q;
      end else if (sp_hit(rd_addr)) begin
         rd_ok = 1'b1;
         for (int i = 0; i < SP_COUNT; i++)
            if (rd_addr[2:0] == 3'(i)) rd_data = sp[i];
      end
   end

endmodule

// File: rtl/nsc_cmd_slave.sv
// nsc_cmd_slave: AXI4 responder for helper commands. Holds the write/read
// FSMs and the command handoff. Optional macro NSC_SLVERR_EN turns illegal
// accesses into SLVERR responses; without it every response is OKAY.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a source holds valid and its payload stable until that edge, and
// ready never waits on valid to rise.
module nsc_cmd_slave import nsc_cmd_pkg::*; (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic [11:0] S_AXI_awid,
   input  logic [31:0] S_AXI_awaddr,
   input  logic [7:0]  S_AXI_awlen,
   input  logic [2:0]  S_AXI_awsize,
   input  logic [1:0]  S_AXI_awburst,
   input  logic        S_AXI_awvalid,
   output logic        S_AXI_awready,
   input  logic [31:0] S_AXI_wdata,
   input  logic [3:0]  S_AXI_wstrb,
   input  logic        S_AXI_wlast,
   input  logic        S_AXI_wvalid,
   output logic        S_AXI_wready,
   output logic [11:0] S_AXI_bid,
   output logic [1:0]  S_AXI_bresp,
   output logic        S_AXI_bvalid,
   input  logic        S_AXI_bready,
   input  logic [11:0] S_AXI_arid,
   input  logic [31:0] S_AXI_araddr,
   input  logic [7:0]  S_AXI_arlen,
   input  logic        S_AXI_arvalid,
   output logic        S_AXI_arready,
   output logic [11:0] S_AXI_rid,
   output logic [31:0] S_AXI_rdata,
   output logic [1:0]  S_AXI_rresp,
   output logic        S_AXI_rlast,
   output logic        S_AXI_rvalid,
   input  logic        S_AXI_rready,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [31:0] cmd_opcode,
   output logic [31:0] cmd_way,
   output logic [31:0] cmd_row,
   output logic [31:0] cmd_arg0,
   output logic [31:0] cmd_arg1,
   output logic [31:0] cmd_arg2,
   output logic [31:0] cmd_arg3,
   input  logic        cmd_done,
   input  logic [31:0] cmd_status,
   output logic [1:0]  dbg_w_state,
   output logic        dbg_r_state
);

   w_state_t w_state;
   r_state_t r_state;

   logic        aw_held, w_held;
   logic [15:0] aw_addr_q;
   logic [11:0] aw_id_q;
   logic        aw_len_nz_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic        w_last_q;

   logic        aw_fire, w_fire, ar_fire;
   logic        wr_commit, reg_wr_en, reg_wr_ok, rd_ok, busy;
   logic [15:0] eff_addr, rd_addr;
   logic [11:0] eff_id;
   logic        eff_len_nz, eff_last;
   logic [31:0] eff_data, rd_data;
   logic [3:0]  eff_strb;
   logic [1:0]  commit_resp, drain_resp, rd_resp;
   logic        start_req, done_evt, launch, overrun;
   logic [SP_COUNT-1:0][31:0] sp;
   logic        unused_ok;

   assign aw_fire = S_AXI_awvalid && S_AXI_awready;
   assign w_fire  = S_AXI_wvalid && S_AXI_wready;
   assign ar_fire = S_AXI_arvalid && S_AXI_arready;

   // A channel latched earlier takes precedence over the live inputs.
   assign eff_addr   = aw_held ? aw_addr_q   : (S_AXI_awaddr[15:0] & ADDR_MASK);
   assign eff_id     = aw_held ? aw_id_q     : S_AXI_awid;
   assign eff_len_nz = aw_held ? aw_len_nz_q : (S_AXI_awlen != 8'd0);
   assign eff_data   = w_held  ? w_data_q    : S_AXI_wdata;
   assign eff_strb   = w_held  ? w_strb_q    : S_AXI_wstrb;
   assign eff_last   = w_held  ? w_last_q    : S_AXI_wlast;

   assign wr_commit = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
   assign reg_wr_en = wr_commit && !eff_len_nz;
   assign rd_addr   = S_AXI_araddr[15:0] & ADDR_MASK;

`ifdef NSC_SLVERR_EN
   assign commit_resp = (eff_len_nz || !reg_wr_ok) ? RESP_SLVERR : RESP_OKAY;
   assign drain_resp  = RESP_SLVERR;
   assign rd_resp     = rd_ok ? RESP_OKAY : RESP_SLVERR;
`else
   assign commit_resp = RESP_OKAY;
   assign drain_resp  = RESP_OKAY;
   assign rd_resp     = RESP_OKAY;
`endif

   // Completion is only accepted once the command has been handed off.
   assign start_req = reg_wr_en && (eff_addr[15:2] == OFF_CC[15:2]) && eff_strb[0] && eff_data[CC_BUSY];
   assign done_evt  = cmd_done && busy && !cmd_valid;
   assign launch    = start_req && (!busy || done_evt);
   assign overrun   = start_req && busy && !done_evt;

   assign dbg_w_state = w_state;
   assign dbg_r_state = r_state;

   assign unused_ok = ^{S_AXI_awsize, S_AXI_awburst, S_AXI_arlen, S_AXI_awaddr[31:16],
                        S_AXI_araddr[31:16], eff_addr[1:0], rd_addr[1:0], rd_ok, reg_wr_ok};

   nsc_cmd_regfile u_regfile (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .wr_en     (reg_wr_en),
      .wr_addr   (eff_addr[15:2]),
      .wr_data   (eff_data),
      .wr_strb   (eff_strb),
      .wr_ok     (reg_wr_ok),
      .rd_addr   (rd_addr[15:2]),
      .rd_data   (rd_data),
      .rd_ok     (rd_ok),
      .launch    (launch),
      .complete  (done_evt),
      .overrun   (overrun),
      .status_in (cmd_status),
      .busy      (busy),
      .sp        (sp)
   );

   // Write FSM: latch AW and W independently, commit, drain bursts, respond.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state       <= W_IDLE;
         S_AXI_awready <= 1'b0;
         S_AXI_wready  <= 1'b0;
         S_AXI_bvalid  <= 1'b0;
         S_AXI_bid     <= '0;
         S_AXI_bresp   <= RESP_OKAY;
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         aw_addr_q     <= '0;
         aw_id_q       <= '0;
         aw_len_nz_q   <= 1'b0;
         w_data_q      <= '0;
         w_strb_q      <= '0;
         w_last_q      <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_fire) begin
                  aw_held       <= 1'b1;
                  aw_addr_q     <= S_AXI_awaddr[15:0] & ADDR_MASK;
                  aw_id_q       <= S_AXI_awid;
                  aw_len_nz_q   <= (S_AXI_awlen != 8'd0);
                  S_AXI_awready <= 1'b0;
               end else if (!aw_held) begin
                  S_AXI_awready <= 1'b1;
               end
               if (w_fire) begin
                  w_held       <= 1'b1;
                  w_data_q     <= S_AXI_wdata;
                  w_strb_q     <= S_AXI_wstrb;
                  w_last_q     <= S_AXI_wlast;
                  S_AXI_wready <= 1'b0;
               end else if (!w_held) begin
                  S_AXI_wready <= 1'b1;
               end
               if (wr_commit) begin
                  aw_held       <= 1'b0;
                  w_held        <= 1'b0;
                  S_AXI_awready <= 1'b0;
                  if (eff_len_nz && !eff_last) begin
                     w_state      <= W_DRAIN;
                     S_AXI_wready <= 1'b1;
                  end else begin
                     w_state      <= W_RESP;
                     S_AXI_wready <= 1'b0;
                     S_AXI_bvalid <= 1'b1;
                     S_AXI_bid    <= eff_id;
                     S_AXI_bresp  <= commit_resp;
                  end
               end
            end
            W_DRAIN: begin
               if (w_fire && S_AXI_wlast) begin
                  w_state      <= W_RESP;
                  S_AXI_wready <= 1'b0;
                  S_AXI_bvalid <= 1'b1;
                  S_AXI_bid    <= aw_id_q;
                  S_AXI_bresp  <= drain_resp;
               end
            end
            W_RESP: begin
               if (S_AXI_bready) begin
                  w_state       <= W_IDLE;
                  S_AXI_bvalid  <= 1'b0;
                  S_AXI_awready <= 1'b1;
                  S_AXI_wready  <= 1'b1;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read FSM: single-beat responses with registered data.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state       <= R_IDLE;
         S_AXI_arready <= 1'b0;
         S_AXI_rvalid  <= 1'b0;
         S_AXI_rlast   <= 1'b0;
         S_AXI_rid     <= '0;
         S_AXI_rdata   <= '0;
         S_AXI_rresp   <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_fire) begin
                  r_state       <= R_DATA;
                  S_AXI_arready <= 1'b0;
                  S_AXI_rvalid  <= 1'b1;
                  S_AXI_rlast   <= 1'b1;
                  S_AXI_rid     <= S_AXI_arid;
                  S_AXI_rdata   <= rd_data;
                  S_AXI_rresp   <= rd_resp;
               end else begin
                  S_AXI_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (S_AXI_rready) begin
                  r_state       <= R_IDLE;
                  S_AXI_arready <= 1'b1;
                  S_AXI_rvalid  <= 1'b0;
                  S_AXI_rlast   <= 1'b0;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Command handoff: snapshot SP0..SP6 on launch, hold until accepted.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         cmd_valid  <= 1'b0;
         cmd_opcode <= '0;
         cmd_way    <= '0;
         cmd_row    <= '0;
         cmd_arg0   <= '0;
         cmd_arg1   <= '0;
         cmd_arg2   <= '0;
         cmd_arg3   <= '0;
      end else if (launch) begin
         cmd_valid  <= 1'b1;
         cmd_opcode <= sp[0];
         cmd_way    <= sp[1];
         cmd_row    <= sp[2];
         cmd_arg0   <= sp[3];
         cmd_arg1   <= sp[4];
         cmd_arg2   <= sp[5];
         cmd_arg3   <= sp[6];
      end else if (cmd_valid && cmd_ready) begin
         cmd_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nsc_cmd_slave.sv
// tb_nsc_cmd_slave: directed bench for nsc_cmd_slave. A vector table covers
// register write/readback; hand-written sequences cover command launch,
// overrun, completion, early W, bursts, back-pressure and mid-hold reset.
module tb_nsc_cmd_slave;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [11:0] S_AXI_awid = '0;
   logic [31:0] S_AXI_awaddr = '0;
   logic [7:0]  S_AXI_awlen = '0;
   logic [2:0]  S_AXI_awsize = 3'd2;
   logic [1:0]  S_AXI_awburst = 2'b01;
   logic        S_AXI_awvalid = 1'b0;
   logic        S_AXI_awready;
   logic [31:0] S_AXI_wdata = '0;
   logic [3:0]  S_AXI_wstrb = '0;
   logic        S_AXI_wlast = 1'b0;
   logic        S_AXI_wvalid = 1'b0;
   logic        S_AXI_wready;
   logic [11:0] S_AXI_bid;
   logic [1:0]  S_AXI_bresp;
   logic        S_AXI_bvalid;
   logic        S_AXI_bready = 1'b0;
   logic [11:0] S_AXI_arid = '0;
   logic [31:0] S_AXI_araddr = '0;
   logic [7:0]  S_AXI_arlen = '0;
   logic        S_AXI_arvalid = 1'b0;
   logic        S_AXI_arready;
   logic [11:0] S_AXI_rid;
   logic [31:0] S_AXI_rdata;
   logic [1:0]  S_AXI_rresp;
   logic        S_AXI_rlast;
   logic        S_AXI_rvalid;
   logic        S_AXI_rready = 1'b0;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [31:0] cmd_opcode, cmd_way, cmd_row, cmd_arg0, cmd_arg1, cmd_arg2, cmd_arg3;
   logic        cmd_done = 1'b0;
   logic [31:0] cmd_status = '0;
   logic [1:0]  dbg_w_state;
   logic        dbg_r_state;

   nsc_cmd_slave dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_awid(S_AXI_awid), .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awlen(S_AXI_awlen),
      .S_AXI_awsize(S_AXI_awsize), .S_AXI_awburst(S_AXI_awburst),
      .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
      .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wlast(S_AXI_wlast),
      .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
      .S_AXI_bid(S_AXI_bid), .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid),
      .S_AXI_bready(S_AXI_bready),
      .S_AXI_arid(S_AXI_arid), .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen),
      .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
      .S_AXI_rid(S_AXI_rid), .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
      .S_AXI_rlast(S_AXI_rlast), .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_way(cmd_way), .cmd_row(cmd_row),
      .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1), .cmd_arg2(cmd_arg2), .cmd_arg3(cmd_arg3),
      .cmd_done(cmd_done), .cmd_status(cmd_status),
      .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
   );

   // ---------------- clock / reset ----------------
   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT, got no handshake expected one", name);
   endtask

   function automatic logic [1:0] exp_resp(input logic ok);
`ifdef NSC_SLVERR_EN
      return ok ? 2'b00 : 2'b10;
`else
      return ok ? 2'b00 : 2'b00;
`endif
   endfunction

   // Handshake monitors, sampled on the falling edge.
   int b_count = 0;
   int cmd_count = 0;
   logic [31:0] cap_opcode, cap_way, cap_row, cap_arg3;
   always @(negedge ACLK) begin
      if (S_AXI_bvalid && S_AXI_bready) b_count++;
      if (cmd_valid && cmd_ready) begin
         cmd_count++;
         cap_opcode = cmd_opcode;
         cap_way    = cmd_way;
         cap_row    = cmd_row;
         cap_arg3   = cmd_arg3;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_b(output logic [1:0] resp, output logic [11:0] id_o);
      bit got = 0;
      S_AXI_bready = 1'b1;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge ACLK);
         if (S_AXI_bvalid) begin
            got  = 1;
            resp = S_AXI_bresp;
            id_o = S_AXI_bid;
         end
      end
      @(posedge ACLK); #1;
      S_AXI_bready = 1'b0;
      if (!got) begin
         resp = 2'b11;
         id_o = '1;
         timeout_fail("b_channel");
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [11:0] id,
                            output logic [1:0] resp, output logic [11:0] id_o);
      bit aw_hs, w_hs;
      @(posedge ACLK); #1;
      S_AXI_awaddr = addr; S_AXI_awid = id; S_AXI_awlen = 8'd0; S_AXI_awvalid = 1'b1;
      S_AXI_wdata = data; S_AXI_wstrb = strb; S_AXI_wlast = 1'b1; S_AXI_wvalid = 1'b1;
      for (int n = 0; n < 50 && (S_AXI_awvalid || S_AXI_wvalid); n++) begin
         @(negedge ACLK);
         aw_hs = S_AXI_awvalid && S_AXI_awready;
         w_hs  = S_AXI_wvalid && S_AXI_wready;
         @(posedge ACLK); #1;
         if (aw_hs) S_AXI_awvalid = 1'b0;
         if (w_hs)  S_AXI_wvalid  = 1'b0;
      end
      if (S_AXI_awvalid || S_AXI_wvalid) begin
         S_AXI_awvalid = 1'b0;
         S_AXI_wvalid  = 1'b0;
         timeout_fail("aw_w_channel");
      end
      wait_b(resp, id_o);
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [11:0] id,
                           output logic [31:0] data, output logic [1:0] resp,
                           output logic [11:0] id_o);
      bit hs = 0;
      bit got = 0;
      @(posedge ACLK); #1;
      S_AXI_araddr = addr; S_AXI_arid = id; S_AXI_arlen = 8'd0; S_AXI_arvalid = 1'b1;
      for (int n = 0; n < 50 && !hs; n++) begin
         @(negedge ACLK);
         hs = S_AXI_arready;
         @(posedge ACLK); #1;
      end
      S_AXI_arvalid = 1'b0;
      if (!hs) timeout_fail("ar_channel");
      S_AXI_rready = 1'b1;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge ACLK);
         if (S_AXI_rvalid) begin
            got  = 1;
            data = S_AXI_rdata;
            resp = S_AXI_rresp;
            id_o = S_AXI_rid;
         end
      end
      @(posedge ACLK); #1;
      S_AXI_rready = 1'b0;
      if (!got) begin
         data = 'x; resp = 2'b11; id_o = '1;
         timeout_fail("r_channel");
      end
   endtask

   task automatic pulse_done(input logic [31:0] status);
      @(posedge ACLK); #1;
      cmd_status = status;
      cmd_done   = 1'b1;
      @(posedge ACLK); #1;
      cmd_done   = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d; logic [1:0] r; logic [11:0] i;
      axi_read(addr, 12'h0AA, d, r, i);
      check(name, d, exp);
   endtask

   task automatic wr_check(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] exp_b);
      logic [1:0] r; logic [11:0] i;
      axi_write(addr, data, 4'hF, 12'h055, r, i);
      check(name, {30'b0, r}, {30'b0, exp_b});
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] raddr;
      logic [31:0] exp_rdata;
      logic        wok;
      logic        rok;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [1:0]  resp;
      logic [11:0] id_o;
      logic [31:0] data;
      int          b_before, c_before, beat;
      bit          aw_hs, w_hs;

      vecs[0] = '{32'h0000_4000, 32'h0000_01A4, 4'hF, 32'h4000, 32'h0000_01A4, 1'b1, 1'b1};
      vecs[1] = '{32'h0000_4004, 32'h0000_0100, 4'hF, 32'h4004, 32'h0000_0100, 1'b1, 1'b1};
      vecs[2] = '{32'h0000_4008, 32'h0000_0100, 4'hF, 32'h4008, 32'h0000_0100, 1'b1, 1'b1};
      vecs[3] = '{32'h0000_4018, 32'hA5A5_5A5A, 4'hA, 32'h4018, 32'hA500_5A00, 1'b1, 1'b1};
      vecs[4] = '{32'h0000_400C, 32'hFFFF_FFFF, 4'h0, 32'h400C, 32'h0000_0000, 1'b1, 1'b1};
      vecs[5] = '{32'h0000_0000, 32'h0000_1234, 4'hF, 32'h0000, 32'h4E53_0001, 1'b0, 1'b1};
      vecs[6] = '{32'h0000_5000, 32'h0000_CAFE, 4'hF, 32'h5000, 32'h0000_0000, 1'b0, 1'b0};
      vecs[7] = '{32'h0000_401C, 32'h0000_0055, 4'hF, 32'h401C, 32'h0000_0000, 1'b0, 1'b0};
      vecs[8] = '{32'hABCD_4010, 32'h1122_3344, 4'hF, 32'h4010, 32'h1122_3344, 1'b1, 1'b1};
      vecs[9] = '{32'h0000_3004, 32'h0000_FFFF, 4'hF, 32'h3004, 32'h0000_0000, 1'b0, 1'b1};

      // Reset state while ARESETN is low.
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check("rst_awready", {31'b0, S_AXI_awready}, 32'd0);
      check("rst_wready",  {31'b0, S_AXI_wready},  32'd0);
      check("rst_arready", {31'b0, S_AXI_arready}, 32'd0);
      check("rst_valids",  {29'b0, S_AXI_bvalid, S_AXI_rvalid, cmd_valid}, 32'd0);
      check("rst_cmd_opcode", cmd_opcode, 32'd0);
      ARESETN = 1'b1;
      @(posedge ACLK); #1;
      check("post_rst_ready", {29'b0, S_AXI_awready, S_AXI_wready, S_AXI_arready}, 32'h7);

      // Table-driven write/readback.
      for (int i = 0; i < 10; i++) begin
         axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, 12'(i + 1), resp, id_o);
         check($sformatf("vec%0d_bresp", i), {30'b0, resp}, {30'b0, exp_resp(vecs[i].wok)});
         check($sformatf("vec%0d_bid", i), {20'b0, id_o}, 32'(i + 1));
         exp_q.push_back(vecs[i].exp_rdata);
         axi_read(vecs[i].raddr, 12'(i + 32), data, resp, id_o);
         check($sformatf("vec%0d_rdata", i), data, exp_q.pop_front());
         check($sformatf("vec%0d_rresp", i), {30'b0, resp}, {30'b0, exp_resp(vecs[i].rok)});
         check($sformatf("vec%0d_rid", i), {20'b0, id_o}, 32'(i + 32));
      end

      // Command launch with cmd_ready high.
      cmd_ready = 1'b1;
      c_before = cmd_count;
      wr_check("launch_bresp", 32'h3000, 32'h1, 2'b00);
      repeat (3) @(posedge ACLK);
      check("launch_count", 32'(cmd_count - c_before), 32'd1);
      check("launch_opcode", cap_opcode, 32'h0000_01A4);
      check("launch_way", cap_way, 32'h0000_0100);
      check("launch_row", cap_row, 32'h0000_0100);
      check("launch_arg3", cap_arg3, 32'hA500_5A00);
      rd_check("cc_busy", 32'h3000, 32'h1);
      pulse_done(32'h1234_5678);
      rd_check("status_after_done", 32'h3004, 32'h1234_5678);
      rd_check("cc_done", 32'h3000, 32'h2);
      wr_check("cc_w1c_bresp", 32'h3000, 32'h2, 2'b00);
      rd_check("cc_cleared", 32'h3000, 32'h0);

      // W three cycles ahead of AW, partial strobe into SP1.
      @(posedge ACLK); #1;
      S_AXI_wdata = 32'hDEAD_BEEF; S_AXI_wstrb = 4'b0011; S_AXI_wlast = 1'b1; S_AXI_wvalid = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_wvalid = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      S_AXI_awaddr = 32'h4004; S_AXI_awid = 12'h007; S_AXI_awlen = 8'd0; S_AXI_awvalid = 1'b1;
      @(negedge ACLK);
      check("early_w_bvalid_pre", {31'b0, S_AXI_bvalid}, 32'd0);
      check("early_w_awready", {31'b0, S_AXI_awready}, 32'd1);
      @(posedge ACLK); #1;
      S_AXI_awvalid = 1'b0;
      check("early_w_bvalid_lat", {31'b0, S_AXI_bvalid}, 32'd1);
      check("early_w_bid", {20'b0, S_AXI_bid}, 32'h007);
      wait_b(resp, id_o);
      rd_check("early_w_sp1", 32'h4004, 32'h0000_BEEF);

      // Back-pressured command plus overrun.
      cmd_ready = 1'b0;
      wr_check("bp_launch_bresp", 32'h3000, 32'h1, 2'b00);
      check("bp_cmd_valid", {31'b0, cmd_valid}, 32'd1);
      wr_check("bp_sp0_write", 32'h4000, 32'h777, 2'b00);
      wr_check("bp_second_start", 32'h3000, 32'h1, 2'b00);
      for (int k = 0; k < 5; k++) begin
         @(negedge ACLK);
         check($sformatf("bp_hold%0d_valid", k), {31'b0, cmd_valid}, 32'd1);
         check($sformatf("bp_hold%0d_opcode", k), cmd_opcode, 32'h0000_01A4);
         check($sformatf("bp_hold%0d_way", k), cmd_way, 32'h0000_BEEF);
      end
      rd_check("cc_busy_overrun", 32'h3000, 32'h5);
      c_before = cmd_count;
      @(posedge ACLK); #1;
      cmd_ready = 1'b1;
      @(posedge ACLK); #1;
      cmd_ready = 1'b0;
      check("bp_handoff_count", 32'(cmd_count - c_before), 32'd1);
      check("bp_valid_dropped", {31'b0, cmd_valid}, 32'd0);
      pulse_done(32'hCAFE_0001);
      rd_check("cc_done_overrun", 32'h3000, 32'h6);
      wr_check("cc_w1c_both", 32'h3000, 32'h6, 2'b00);
      rd_check("cc_cleared2", 32'h3000, 32'h0);
      pulse_done(32'h0000_0099);
      rd_check("idle_done_status", 32'h3004, 32'hCAFE_0001);
      rd_check("idle_done_cc", 32'h3000, 32'h0);

      // awlen = 3 burst: drained, one B, no register change.
      b_before = b_count;
      @(posedge ACLK); #1;
      S_AXI_awaddr = 32'h4008; S_AXI_awid = 12'h0B5; S_AXI_awlen = 8'd3; S_AXI_awvalid = 1'b1;
      S_AXI_wdata = 32'h0000_0BAD; S_AXI_wstrb = 4'hF; S_AXI_wlast = 1'b0; S_AXI_wvalid = 1'b1;
      beat = 0;
      for (int n = 0; n < 50 && (S_AXI_awvalid || S_AXI_wvalid); n++) begin
         @(negedge ACLK);
         aw_hs = S_AXI_awvalid && S_AXI_awready;
         w_hs  = S_AXI_wvalid && S_AXI_wready;
         @(posedge ACLK); #1;
         if (aw_hs) S_AXI_awvalid = 1'b0;
         if (w_hs) begin
            beat++;
            if (beat == 4) S_AXI_wvalid = 1'b0;
            else S_AXI_wlast = (beat == 3);
         end
      end
      if (S_AXI_awvalid || S_AXI_wvalid) begin
         S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
         timeout_fail("burst_aw_w");
      end
      S_AXI_wlast = 1'b0;
      wait_b(resp, id_o);
      check("burst_bresp", {30'b0, resp}, {30'b0, exp_resp(1'b0)});
      check("burst_bid", {20'b0, id_o}, 32'h0B5);
      repeat (4) @(posedge ACLK);
      check("burst_one_b", 32'(b_count - b_before), 32'd1);
      rd_check("burst_sp2_unchanged", 32'h4008, 32'h0000_0100);

      // B and R held under back-pressure, then reset mid-hold.
      wr_check("hold_launch", 32'h3000, 32'h1, 2'b00);
      @(posedge ACLK); #1;
      S_AXI_awaddr = 32'h4014; S_AXI_awid = 12'h05A; S_AXI_awlen = 8'd0; S_AXI_awvalid = 1'b1;
      S_AXI_wdata = 32'h1; S_AXI_wstrb = 4'hF; S_AXI_wlast = 1'b1; S_AXI_wvalid = 1'b1;
      S_AXI_araddr = 32'h4000; S_AXI_arid = 12'h03C; S_AXI_arvalid = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0; S_AXI_arvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge ACLK);
         check($sformatf("hold%0d_bvalid", k), {31'b0, S_AXI_bvalid}, 32'd1);
         check($sformatf("hold%0d_bid", k), {20'b0, S_AXI_bid}, 32'h05A);
         check($sformatf("hold%0d_rvalid", k), {31'b0, S_AXI_rvalid}, 32'd1);
         check($sformatf("hold%0d_rid", k), {20'b0, S_AXI_rid}, 32'h03C);
         check($sformatf("hold%0d_rdata", k), S_AXI_rdata, 32'h0000_0777);
      end
      #2;
      ARESETN = 1'b0;
      #1;
      check("midrst_valids", {29'b0, S_AXI_bvalid, S_AXI_rvalid, cmd_valid}, 32'd0);
      check("midrst_ready", {29'b0, S_AXI_awready, S_AXI_wready, S_AXI_arready}, 32'd0);
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      repeat (2) @(posedge ACLK);
      rd_check("after_rst_cc", 32'h3000, 32'h0);
      rd_check("after_rst_sp0", 32'h4000, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
